ebus_xfer_seq: RTL and testbench

- Sequences one CPU-side EBUS data transfer on each transfer request from the CTL control outputs.
- Sits directly downstream of CTL: consumes the EBUS XFER, T-to-E / E-to-T enables, parity-out and AD-to-EBUS halves.
- Drives EBUS demand, data and parity, then waits for the device's transfer acknowledge.
- Returns captured read data, a done pulse, a timeout pulse and a parity-error flag to the EDP/CTL side.

---
 rtl/ebus_xfer_seq.sv | 166 ++++++++++++++++
 tb/tb_ebus_xfer_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_xfer_seq.sv
// EBUS transfer sequencer: turns one CTL transfer request into an EBUS
// setup/demand/acknowledge/release handshake and reports done, timeout and read parity.
module ebus_xfer_seq #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctl_ebus_xfer,
  input  logic        ctl_ebus_t_to_e_en,
  input  logic        ctl_ebus_e_to_t_en,
  input  logic        ctl_ebus_parity_out,
  input  logic        ctl_ad_to_ebus_l,
  input  logic        ctl_ad_to_ebus_r,
  input  logic [35:0] ad,
  input  logic [35:0] ebus_data_in,
  input  logic        ebus_parity_in,
  input  logic        ebus_xfer_ack,
  output logic        ebus_demand,
  output logic [35:0] ebus_data_out,
  output logic [1:0]  ebus_data_oe,
  output logic        ebus_parity_out,
  output logic [35:0] rd_data,
  output logic        rd_parity_err,
  output logic        xfer_busy,
  output logic        xfer_done,
  output logic        xfer_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DEMAND, S_WAIT_ACK, S_RELEASE, S_HOLD, S_DONE, S_ABORT
  } state_t;

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [9:0] TMO_LOAD   = 10'(TIMEOUT_CYCLES - 1);
  localparam bit         HAS_HOLD   = (HOLD_CYCLES > 0);
  localparam logic [3:0] HOLD_LOAD  = HAS_HOLD ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        wr_q, wr_d;
  logic [35:0] data_q, data_d;
  logic [1:0]  oe_q, oe_d;
  logic        par_q, par_d;
  logic [35:0] rd_data_q, rd_data_d;
  logic        perr_q, perr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      oe_q      <= '0;
      par_q     <= 1'b0;
      rd_data_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      par_q     <= par_d;
      rd_data_q <= rd_data_d;
      perr_q    <= perr_d;
    end
  end

  // Bus drive is released on the edge that enters DONE or ABORT, so neither state drives.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    wr_d      = wr_q;
    data_d    = data_q;
    oe_d      = oe_q;
    par_d     = par_q;
    rd_data_d = rd_data_q;
    perr_d    = perr_q;
    case (state_q)
      S_IDLE: begin
        if (ctl_ebus_xfer && (ctl_ebus_t_to_e_en || ctl_ebus_e_to_t_en)) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
          wr_d    = ctl_ebus_t_to_e_en;
          if (ctl_ebus_t_to_e_en) begin
            data_d = ad;
            oe_d   = {ctl_ad_to_ebus_r, ctl_ad_to_ebus_l};
            par_d  = ctl_ebus_parity_out;
          end else begin
            data_d = '0;
            oe_d   = '0;
            par_d  = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) state_d = S_DEMAND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DEMAND: begin
        state_d = S_WAIT_ACK;
        tmo_d   = TMO_LOAD;
      end
      S_WAIT_ACK: begin
        // An acknowledge on the last timeout clock still wins over the abort.
        if (ebus_xfer_ack) begin
          state_d = S_RELEASE;
          if (!wr_q) begin
            rd_data_d = ebus_data_in;
            perr_d    = ~^{ebus_data_in, ebus_parity_in};
          end
        end else if (tmo_q == 10'd0) begin
          state_d = S_ABORT;
          data_d  = '0;
          oe_d    = '0;
          par_d   = 1'b0;
        end else begin
          tmo_d = tmo_q - 10'd1;
        end
      end
      S_RELEASE: begin
        if (!ebus_xfer_ack) begin
          if (wr_q && HAS_HOLD) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = S_DONE;
            data_d  = '0;
            oe_d    = '0;
            par_d   = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          data_d  = '0;
          oe_d    = '0;
          par_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ebus_demand     = (state_q == S_DEMAND) || (state_q == S_WAIT_ACK);
  assign ebus_data_out   = data_q;
  assign ebus_data_oe    = oe_q;
  assign ebus_parity_out = par_q;
  assign rd_data         = rd_data_q;
  assign rd_parity_err   = perr_q;
  assign xfer_busy       = (state_q != S_IDLE);
  assign xfer_done       = (state_q == S_DONE);
  assign xfer_timeout    = (state_q == S_ABORT);

endmodule

// File: tb/tb_ebus_xfer_seq.sv
// Directed bench for ebus_xfer_seq: a vector table of complete transfers plus
// hand-written sequences for timeout, reset and acknowledge-timing corners.
module tb_ebus_xfer_seq;
  localparam int SETUP = 2;
  localparam int TMO   = 64;
  localparam int HOLD  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctl_ebus_xfer = 1'b0;
  logic        ctl_ebus_t_to_e_en = 1'b0;
  logic        ctl_ebus_e_to_t_en = 1'b0;
  logic        ctl_ebus_parity_out = 1'b0;
  logic        ctl_ad_to_ebus_l = 1'b0;
  logic        ctl_ad_to_ebus_r = 1'b0;
  logic [35:0] ad = '0;
  logic [35:0] ebus_data_in = '0;
  logic        ebus_parity_in = 1'b0;
  logic        ebus_xfer_ack = 1'b0;
  logic        ebus_demand;
  logic [35:0] ebus_data_out;
  logic [1:0]  ebus_data_oe;
  logic        ebus_parity_out;
  logic [35:0] rd_data;
  logic        rd_parity_err;
  logic        xfer_busy;
  logic        xfer_done;
  logic        xfer_timeout;

  ebus_xfer_seq #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_ebus_xfer(ctl_ebus_xfer), .ctl_ebus_t_to_e_en(ctl_ebus_t_to_e_en),
    .ctl_ebus_e_to_t_en(ctl_ebus_e_to_t_en), .ctl_ebus_parity_out(ctl_ebus_parity_out),
    .ctl_ad_to_ebus_l(ctl_ad_to_ebus_l), .ctl_ad_to_ebus_r(ctl_ad_to_ebus_r),
    .ad(ad), .ebus_data_in(ebus_data_in), .ebus_parity_in(ebus_parity_in),
    .ebus_xfer_ack(ebus_xfer_ack), .ebus_demand(ebus_demand),
    .ebus_data_out(ebus_data_out), .ebus_data_oe(ebus_data_oe),
    .ebus_parity_out(ebus_parity_out), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_timeout(xfer_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, l, r, par;
    logic [35:0] adv, bus;
    logic        busPar;
    logic [1:0]  expOe;
    logic [35:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;
  int   doneCount = 0;
  int   tmoCount = 0;
  logic oeSeen = 1'b0;

  // Sampled on the rising edge, i.e. the value held through the previous cycle.
  always @(posedge clk) begin
    if (xfer_done) doneCount++;
    if (xfer_timeout) tmoCount++;
    if (ebus_data_oe != 2'b00) oeSeen = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: sim time expired, wanted $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitUntil(input string name, input int sel);
    bit hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((sel == 0 && ebus_demand) || (sel == 1 && !ebus_demand) ||
          (sel == 2 && xfer_done) || (sel == 3 && xfer_timeout)) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: bound of 200 clocks expired, event never seen", name);
    end
  endtask

  // Presents a one-clock request, then scrambles the inputs to prove they were latched.
  task automatic applyStimulus(input logic wr, input logic rd, input logic l, input logic r,
                               input logic par, input logic [35:0] adv);
    ctl_ebus_t_to_e_en  = wr;
    ctl_ebus_e_to_t_en  = rd;
    ctl_ad_to_ebus_l    = l;
    ctl_ad_to_ebus_r    = r;
    ctl_ebus_parity_out = par;
    ad                  = adv;
    ctl_ebus_xfer       = 1'b1;
    tick();
    ctl_ebus_xfer       = 1'b0;
    ctl_ad_to_ebus_l    = ~l;
    ctl_ad_to_ebus_r    = ~r;
    ctl_ebus_parity_out = ~par;
    ad                  = ~adv;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int d0 = doneCount;
    oeSeen = 1'b0;
    applyStimulus(v.wr, v.rd, v.l, v.r, v.par, v.adv);
    waitUntil($sformatf("v%0d_demand", idx), 0);
    checkOutput($sformatf("v%0d_oe", idx), 64'(ebus_data_oe), 64'(v.expOe));
    checkOutput($sformatf("v%0d_dout", idx), 64'(ebus_data_out), v.wr ? 64'(v.adv) : 64'd0);
    checkOutput($sformatf("v%0d_pout", idx), 64'(ebus_parity_out), v.wr ? 64'(v.par) : 64'd0);
    ebus_data_in   = v.bus;
    ebus_parity_in = v.busPar;
    ebus_xfer_ack  = 1'b1;
    waitUntil($sformatf("v%0d_release", idx), 1);
    ebus_data_in   = ~v.bus;
    ebus_parity_in = ~v.busPar;
    ebus_xfer_ack  = 1'b0;
    waitUntil($sformatf("v%0d_done", idx), 2);
    tick();
    tick();
    checkOutput($sformatf("v%0d_rd_data", idx), 64'(rd_data), 64'(v.expRd));
    checkOutput($sformatf("v%0d_perr", idx), 64'(rd_parity_err), 64'(v.expErr));
    checkOutput($sformatf("v%0d_oe_seen", idx), 64'(oeSeen), 64'(v.expOe != 2'b00));
    checkOutput($sformatf("v%0d_done_count", idx), 64'(doneCount - d0), 64'd1);
    checkOutput($sformatf("v%0d_idle", idx), 64'(xfer_busy), 64'd0);
  endtask

  initial begin
    int d0, t0, n;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0, 36'o777000_000777, 1'b1,
                2'b00, 36'o777000_000777, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0, 36'o777000_000777, 1'b0,
                2'b00, 36'o777000_000777, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 36'o123456_654321, 36'o111111_111111, 1'b0,
                2'b11, 36'o777000_000777, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 36'o707070_070707, 36'o222222_222222, 1'b1,
                2'b10, 36'o777000_000777, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 36'o555555_555555, 36'o000000_000001, 1'b0,
                2'b00, 36'o000000_000001, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0, 36'o0, 1'b0,
                2'b00, 36'o0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0, 36'o525252_525252, 1'b1,
                2'b00, 36'o525252_525252, 1'b0};

    tick();
    tick();
    checkOutput("reset_demand", 64'(ebus_demand), 64'd0);
    checkOutput("reset_oe", 64'(ebus_data_oe), 64'd0);
    checkOutput("reset_dout", 64'(ebus_data_out), 64'd0);
    checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
    checkOutput("reset_busy", 64'(xfer_busy), 64'd0);
    checkOutput("reset_pulses", 64'({xfer_done, xfer_timeout, rd_parity_err, ebus_parity_out}), 64'd0);
    rst_n = 1'b1;
    tick();

    // A request with neither direction enable must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 36'o1);
    checkOutput("nodir_busy0", 64'(xfer_busy), 64'd0);
    tick();
    checkOutput("nodir_busy1", 64'(xfer_busy), 64'd0);
    checkOutput("nodir_oe", 64'(ebus_data_oe), 64'd0);

    // Full-word write with ack three clocks after demand and one hold clock.
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 36'o123456_654321);
    checkOutput("wr_oe_setup", 64'(ebus_data_oe), 64'd3);
    checkOutput("wr_dout_setup", 64'(ebus_data_out), 64'(36'o123456_654321));
    checkOutput("wr_par_setup", 64'(ebus_parity_out), 64'd1);
    checkOutput("wr_demand_setup0", 64'(ebus_demand), 64'd0);
    checkOutput("wr_busy_setup", 64'(xfer_busy), 64'd1);
    tick();
    checkOutput("wr_demand_setup1", 64'(ebus_demand), 64'd0);
    tick();
    checkOutput("wr_demand_rise", 64'(ebus_demand), 64'd1);
    tick();
    tick();
    tick();
    checkOutput("wr_demand_wait", 64'(ebus_demand), 64'd1);
    checkOutput("wr_dout_wait", 64'(ebus_data_out), 64'(36'o123456_654321));
    ebus_xfer_ack = 1'b1;
    tick();
    checkOutput("wr_demand_release", 64'(ebus_demand), 64'd0);
    checkOutput("wr_oe_release", 64'(ebus_data_oe), 64'd3);
    ebus_xfer_ack = 1'b0;
    tick();
    checkOutput("wr_oe_hold", 64'(ebus_data_oe), 64'd3);
    checkOutput("wr_done_hold", 64'(xfer_done), 64'd0);
    tick();
    checkOutput("wr_done_pulse", 64'(xfer_done), 64'd1);
    checkOutput("wr_oe_done", 64'(ebus_data_oe), 64'd0);
    checkOutput("wr_dout_done", 64'(ebus_data_out), 64'd0);
    tick();
    checkOutput("wr_done_low", 64'(xfer_done), 64'd0);
    checkOutput("wr_busy_end", 64'(xfer_busy), 64'd0);
    tick();
    checkOutput("wr_done_count", 64'(doneCount - d0), 64'd1);

    for (int i = 0; i < 7; i++) runVector(i, vecs[i]);

    // Read that is never acknowledged.
    d0 = doneCount;
    t0 = tmoCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0);
    ebus_data_in = 36'o444444_444444;
    waitUntil("tmo_demand", 0);
    tick();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (xfer_timeout) break;
    end
    checkOutput("tmo_latency", 64'(n), 64'(TMO));
    checkOutput("tmo_demand_low", 64'(ebus_demand), 64'd0);
    tick();
    checkOutput("tmo_pulse_low", 64'(xfer_timeout), 64'd0);
    checkOutput("tmo_busy_end", 64'(xfer_busy), 64'd0);
    tick();
    checkOutput("tmo_count", 64'(tmoCount - t0), 64'd1);
    checkOutput("tmo_no_done", 64'(doneCount - d0), 64'd0);
    checkOutput("tmo_rd_kept", 64'(rd_data), 64'(vecs[6].expRd));

    // Left-half write; a second request during WAIT_ACK is dropped.
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 36'o765432_123456);
    waitUntil("half_demand", 0);
    checkOutput("half_oe_demand", 64'(ebus_data_oe), 64'd1);
    tick();
    ctl_ebus_xfer      = 1'b1;
    ctl_ebus_t_to_e_en = 1'b1;
    ctl_ad_to_ebus_l   = 1'b1;
    ctl_ad_to_ebus_r   = 1'b1;
    tick();
    ctl_ebus_xfer = 1'b0;
    checkOutput("half_oe_wait", 64'(ebus_data_oe), 64'd1);
    ebus_xfer_ack = 1'b1;
    waitUntil("half_release", 1);
    checkOutput("half_oe_release", 64'(ebus_data_oe), 64'd1);
    ebus_xfer_ack = 1'b0;
    waitUntil("half_done", 2);
    repeat (6) tick();
    checkOutput("half_done_count", 64'(doneCount - d0), 64'd1);
    checkOutput("half_idle", 64'(xfer_busy), 64'd0);

    // Asynchronous reset while waiting for the acknowledge.
    d0 = doneCount;
    t0 = tmoCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 36'o111111_222222);
    waitUntil("rst_demand", 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_demand_async", 64'(ebus_demand), 64'd0);
    checkOutput("rst_oe_async", 64'(ebus_data_oe), 64'd0);
    checkOutput("rst_busy_async", 64'(xfer_busy), 64'd0);
    checkOutput("rst_rd_cleared", 64'(rd_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_no_pulses", 64'((doneCount - d0) + (tmoCount - t0)), 64'd0);
    runVector(7, vecs[0]);

    // Acknowledge arrives on the final timeout clock and is held through RELEASE.
    d0 = doneCount;
    t0 = tmoCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'o0);
    ebus_data_in   = 36'o000000_000007;
    ebus_parity_in = 1'b0;
    waitUntil("late_demand", 0);
    tick();
    repeat (TMO - 1) tick();
    checkOutput("late_still_waiting", 64'({ebus_demand, xfer_timeout}), 64'd2);
    ebus_xfer_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("late_release_%0d", i), 64'({ebus_demand, xfer_busy, xfer_done, xfer_timeout}), 64'b0100);
      tick();
    end
    ebus_xfer_ack = 1'b0;
    tick();
    checkOutput("late_done_pulse", 64'(xfer_done), 64'd1);
    tick();
    tick();
    checkOutput("late_no_timeout", 64'(tmoCount - t0), 64'd0);
    checkOutput("late_done_count", 64'(doneCount - d0), 64'd1);
    checkOutput("late_rd_data", 64'(rd_data), 64'(36'o000000_000007));
    checkOutput("late_perr", 64'(rd_parity_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
